instr_sequencer: RTL and testbench

Instruction fetch and issue sequencer for the CU. Reads 20-bit instructions from a synchronous instruction ROM and presents each one on the CU `instr` input. Each instruction is held for exactly the number of cycles the CU FSM spends on its class, so the next instruction is on `instr` when the CU returns to DECODE. Sits between the instruction ROM and the CU, and drives run/halt status to the top level.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/hold_counter.sv | 29 ++
 rtl/instr_sequencer.sv | 143 ++++++++++++++
 tb/tb_instr_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings, widths and FSM states for the instruction sequencer.
package cpu_pkg;

  localparam int unsigned INSTR_WIDTH  = 20;
  localparam int unsigned CLS_MSB      = 19;
  localparam int unsigned PC_BITS      = 5;
  localparam int unsigned CNT_BITS     = 3;
  localparam int unsigned RETIRE_BITS  = 16;

  localparam int unsigned STD_CYCLES   = 3;
  localparam int unsigned LOAD_CYCLES  = 4;
  localparam int unsigned STORE_CYCLES = 3;

  localparam logic [1:0] CLS_HALT  = 2'b00;
  localparam logic [1:0] CLS_STD   = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LEAD,
    ST_ISSUE,
    ST_HALTED
  } state_t;

  // Number of cycles the CU spends on an instruction of the given class.
  function automatic logic [CNT_BITS-1:0] hold_cycles(input logic [1:0] cls);
    case (cls)
      CLS_STD:   hold_cycles = CNT_BITS'(STD_CYCLES);
      CLS_LOAD:  hold_cycles = CNT_BITS'(LOAD_CYCLES);
      CLS_STORE: hold_cycles = CNT_BITS'(STORE_CYCLES);
      default:   hold_cycles = '0;
    endcase
  endfunction

endpackage

// File: rtl/hold_counter.sv
// Loadable down-counter with zero flag; sets how long each instruction is held.
module hold_counter
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                load,
  input  logic [CNT_BITS-1:0] load_val,
  output logic                zero_c
);

  logic [CNT_BITS-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_BITS'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/instr_sequencer.sv
// Fetches instructions from a synchronous ROM and holds each on instr for its class cycle count.
// Optional feature: define INSTR_RETIRE_COUNT_EN to add the saturating `retired` counter output.
module instr_sequencer
  import cpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PC_BITS-1:0]     start_pc,
  input  logic                   abort,
  output logic [PC_BITS-1:0]     imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   halted
`ifdef INSTR_RETIRE_COUNT_EN
  ,
  output logic [RETIRE_BITS-1:0] retired
`endif
);

  state_t                 state;
  state_t                 state_next;
  logic [INSTR_WIDTH-1:0] instr_next;
  logic [PC_BITS-1:0]     pc_next;
  logic [PC_BITS-1:0]     addr_next;
  logic                   cnt_clr;
  logic                   cnt_load;
  logic [CNT_BITS-1:0]    cnt_load_val;
  logic                   cnt_zero_c;
  logic [1:0]             fetched_cls;
  logic                   fetched_halt;

  assign fetched_cls  = imem_data[CLS_MSB -: 2];
  assign fetched_halt = (fetched_cls == CLS_HALT);

  hold_counter u_hold (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero_c   (cnt_zero_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      instr     <= '0;
      pc        <= '0;
      imem_addr <= '0;
      busy      <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_next;
      instr     <= instr_next;
      pc        <= pc_next;
      imem_addr <= addr_next;
      busy      <= (state_next == ST_FETCH) || (state_next == ST_LEAD) ||
                   (state_next == ST_ISSUE);
      halted    <= (state_next == ST_HALTED);
    end
  end

  // Next state; abort outranks start and instruction completion.
  always_comb begin
    state_next   = state;
    instr_next   = instr;
    pc_next      = pc;
    addr_next    = imem_addr;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = hold_cycles(fetched_cls) - CNT_BITS'(1);

    if (abort) begin
      state_next = ST_IDLE;
      instr_next = '0;
      cnt_clr    = 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: begin
          instr_next = '0;
          if (start) begin
            pc_next    = start_pc;
            addr_next  = start_pc;
            state_next = ST_FETCH;
          end
        end
        ST_FETCH: state_next = ST_LEAD;
        ST_LEAD: begin
          if (fetched_halt) begin
            instr_next = '0;
            state_next = ST_HALTED;
          end else begin
            instr_next = imem_data;
            cnt_load   = 1'b1;
            addr_next  = pc + PC_BITS'(1);
            state_next = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // ROM already holds pc+1 here, so the next instruction follows with no bubble.
          if (cnt_zero_c) begin
            pc_next   = pc + PC_BITS'(1);
            addr_next = pc + PC_BITS'(2);
            if (fetched_halt) begin
              instr_next = '0;
              state_next = ST_HALTED;
            end else begin
              instr_next = imem_data;
              cnt_load   = 1'b1;
            end
          end
        end
        default: begin
          instr_next = '0;
          state_next = ST_IDLE;
        end
      endcase
    end
  end

`ifdef INSTR_RETIRE_COUNT_EN
  logic accept_c;
  logic retire_c;

  assign accept_c = !abort && start && ((state == ST_IDLE) || (state == ST_HALTED));
  assign retire_c = !abort && (state == ST_ISSUE) && cnt_zero_c;

  // Saturating count of completed non-HALT instructions since the last accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired <= '0;
    end else if (accept_c) begin
      retired <= '0;
    end else if (retire_c && (retired != '1)) begin
      retired <= retired + RETIRE_BITS'(1);
    end
  end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a program-level model queues expected issues, a monitor checks them.
// Define INSTR_RETIRE_COUNT_EN to also check the `retired` output.
module tb_instr_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  start_pc;
  logic        abort;
  logic [4:0]  imem_addr;
  logic [19:0] imem_data;
  logic [19:0] instr;
  logic [4:0]  pc;
  logic        busy;
  logic        halted;
`ifdef INSTR_RETIRE_COUNT_EN
  logic [15:0] retired;
`endif

  instr_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_pc  (start_pc),
    .abort     (abort),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .instr     (instr),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted)
`ifdef INSTR_RETIRE_COUNT_EN
    ,
    .retired   (retired)
`endif
  );

  typedef struct {
    logic [4:0]  pc;
    logic [19:0] ins;
    int          hold;
  } rec_t;

  rec_t        exp_q[$];
  logic [19:0] rom [32];
  int          hold_tab [4] = '{0, 3, 4, 3};
  int          total = 0;
  int          bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge clk) imem_data <= rom[imem_addr];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: one run = consecutive samples with the same nonzero instr and pc.
  logic [19:0] run_instr;
  logic [4:0]  run_pc;
  logic [4:0]  run_next;
  int          run_len;
  int          run_addr_bad;
  bit          run_open = 1'b0;

  always @(negedge clk) begin
    rec_t e;
    if (run_open && (instr == '0 || instr != run_instr || pc != run_pc)) begin
      run_open = 1'b0;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_issue pc=%0d instr=%h", run_pc, run_instr);
      end else begin
        e = exp_q.pop_front();
        check("issue_pc", 32'(run_pc), 32'(e.pc));
        check("issue_instr", 32'(run_instr), 32'(e.ins));
        check("issue_hold", 32'(run_len), 32'(e.hold));
        check("issue_imem_addr", 32'(run_addr_bad), 32'd0);
      end
    end
    if (instr != '0 && !run_open) begin
      run_open     = 1'b1;
      run_instr    = instr;
      run_pc       = pc;
      run_len      = 0;
      run_addr_bad = 0;
    end
    if (run_open) begin
      run_len++;
      run_next = run_pc + 5'd1;
      if (imem_addr !== run_next) run_addr_bad++;
    end
  end

  // Program-level model followed by the matching stimulus; abort_k<0 runs to HALT.
  task automatic run_prog(input logic [4:0] spc, input int abort_k,
                          input bit poke, input logic [4:0] poke_pc);
    logic [4:0]  pcm;
    logic [19:0] ins;
    int          s = 0;
    int          n = 0;
    bit          halts = 1'b0;
    bit          aborting = 1'b0;
    int          end_c;
    bit          poke_ok;
    pcm = spc;
    for (int k = 0; k < 40; k++) begin
      ins = rom[pcm];
      if (ins[19:18] == 2'b00) begin
        halts = 1'b1;
        break;
      end
      if (k == abort_k) begin
        aborting = 1'b1;
        exp_q.push_back('{pcm, ins, 2});
        break;
      end
      exp_q.push_back('{pcm, ins, hold_tab[ins[19:18]]});
      s += hold_tab[ins[19:18]];
      n++;
      pcm = pcm + 5'd1;
    end
    end_c   = halts ? 3 + s : 5 + s;
    poke_ok = poke && (halts ? (5 <= 2 + s) : (5 < 4 + s));

    @(negedge clk);
    start    = 1'b1;
    start_pc = spc;
    for (int c = 1; c <= end_c; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
`ifdef INSTR_RETIRE_COUNT_EN
      if (c == 1) check("retired_cleared", 32'(retired), 32'd0);
`endif
      if (c == 3 && (n > 0 || aborting)) begin
        ins = rom[spc];
        check("first_instr", 32'(instr), 32'(ins));
        check("first_pc", 32'(pc), 32'(spc));
      end
      if (halts && c == 2 + s) begin
        check("busy_before_halt", 32'(busy), 32'd1);
        check("halted_before_halt", 32'(halted), 32'd0);
      end
      if (poke_ok && c == 5) begin
        start    = 1'b1;
        start_pc = poke_pc;
      end
      if (aborting && c == 4 + s) abort = 1'b1;
    end
    if (halts) begin
      check("halted", 32'(halted), 32'd1);
      check("busy_at_halt", 32'(busy), 32'd0);
      check("instr_at_halt", 32'(instr), 32'd0);
      check("pc_at_halt", 32'(pc), 32'(pcm));
    end else begin
      check("instr_after_abort", 32'(instr), 32'd0);
      check("busy_after_abort", 32'(busy), 32'd0);
      check("halted_after_abort", 32'(halted), 32'd0);
    end
`ifdef INSTR_RETIRE_COUNT_EN
    check("retired", 32'(retired), 32'(n));
`endif
  endtask

  task automatic load_prog1();
    for (int i = 0; i < 32; i++) rom[i] = '0;
    rom[0] = 20'h4_1230;
    rom[1] = 20'h8_4050;
    rom[2] = 20'hC_8060;
    rom[3] = 20'h0_0000;
  endtask

  initial begin
    int hp;
    rst      = 1'b0;
    start    = 1'b0;
    start_pc = '0;
    abort    = 1'b0;
    load_prog1();
    repeat (3) @(negedge clk);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed program std/load/store/halt, with a start pulse while busy.
    run_prog(5'd0, -1, 1'b1, 5'd17);

    // Start and abort together from HALTED: abort wins.
    @(negedge clk);
    start    = 1'b1;
    abort    = 1'b1;
    start_pc = 5'd5;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_halted", 32'(halted), 32'd0);
    check("start_abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("start_abort_busy2", 32'(busy), 32'd0);
    check("start_abort_instr", 32'(instr), 32'd0);

    // Reset asserted on the second hold cycle of the first instruction.
    exp_q.push_back('{5'd0, 20'h4_1230, 2});
    @(negedge clk);
    start    = 1'b1;
    start_pc = 5'd0;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    check("midrst_instr", 32'(instr), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_pc", 32'(pc), 32'd0);
    check("midrst_imem_addr", 32'(imem_addr), 32'd0);
`ifdef INSTR_RETIRE_COUNT_EN
    check("midrst_retired", 32'(retired), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("postrst_busy", 32'(busy), 32'd0);
    check("postrst_halted", 32'(halted), 32'd0);

    // Abort on the second cycle of the load, then restart at 2.
    run_prog(5'd0, 1, 1'b0, 5'd0);
    run_prog(5'd2, -1, 1'b0, 5'd0);

    // PC wrap: all std instructions from 31, aborted during pc 3.
    for (int i = 0; i < 32; i++) rom[i] = {2'b01, 18'($urandom)};
    run_prog(5'd31, 4, 1'b1, 5'd9);

    // Random programs, each with at least one HALT somewhere.
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 32; i++) rom[i] = 20'($urandom);
      hp = int'($urandom_range(0, 31));
      rom[hp] = {2'b00, 18'($urandom)};
      run_prog(5'($urandom_range(0, 31)), (t % 3 == 2) ? int'($urandom_range(0, 3)) : -1,
               t[0], 5'($urandom));
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
